// File: rtl/maxpool_wb_sched.sv
// maxpool_wb_sched
// Write-back scheduler that sits between the maxpool stage and the DRAM write
// port. It takes 64-bit or 48-bit result groups, packs them densely into 64-bit
// words (oldest data in the LSBs) and issues each word to DRAM with a
// sequential address. At the end of a layer it flushes any zero-padded partial
// word and then pulses done.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start             one-cycle layer start pulse (honoured only when idle)
//   base_addr         first DRAM word address, sampled on start
//   num_groups        groups in the layer, sampled on start (0 is legal)
//   in_valid/in_ready group handshake from maxpool
//   in_len48          1 = 48-bit group in in_data[47:0], 0 = 64-bit group
//   in_data           group payload
//   wr_valid/wr_ready DRAM write handshake
//   wr_addr, wr_data  registered DRAM request (held while stalled)
//   busy              scheduler is not idle
//   done              one-cycle end-of-layer pulse
module maxpool_wb_sched #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_groups,
  input  logic              in_valid,
  input  logic              in_len48,
  input  logic [63:0]       in_data,
  output logic              in_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [127:0]        pk_buf_p0;
  logic [3:0]          fill_p0;
  logic [CNT_W-1:0]    grp_cnt, num_q, grp_nxt;
  logic [ADDR_W-1:0]   word_idx, base_q;

  logic                out_free, accept, drain, flush_part;
  logic [3:0]          fill_base, fill_nxt;
  logic [127:0]        buf_shift, buf_nxt;

  // Places a group at a 16-bit-unit offset inside the 128-bit packing
  // buffer. The unused top of a 48-bit group is forced to zero so that the
  // bits above the fill level stay zero; that is what lets insertion be a
  // plain OR and a flushed partial word come out zero-padded.
  function automatic logic [127:0] place_group(input logic [63:0] d,
                                               input logic        len48,
                                               input logic [3:0]  off_units);
    logic [127:0] ext;
    ext = {64'b0, (len48 ? {16'b0, d[47:0]} : d)};
    return ext << {off_units, 4'b0000};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    out_free   = !wr_valid || wr_ready;
    in_ready   = (state == RUN) && (fill_p0 <= 4'd4);
    accept     = in_valid && in_ready;
    drain      = ((state == RUN) || (state == FLUSH)) && (fill_p0 >= 4'd4) && out_free;
    flush_part = (state == FLUSH) && (fill_p0 != 4'd0) && (fill_p0 < 4'd4) && out_free;
    grp_nxt    = grp_cnt + CNT_W'(1);

    // A drain and an accept in the same cycle: the new group lands right
    // above whatever survives the 64-bit shift.
    buf_shift  = drain ? (pk_buf_p0 >> 64) : pk_buf_p0;
    fill_base  = drain ? (fill_p0 - 4'd4) : fill_p0;
    buf_nxt    = buf_shift;
    fill_nxt   = fill_base;
    if (accept) begin
      buf_nxt  = buf_shift | place_group(in_data, in_len48, fill_base);
      fill_nxt = fill_base + (in_len48 ? 4'd3 : 4'd4);
    end

    case (state)
      IDLE:    if (start) state_nxt = (num_groups == '0) ? FLUSH : RUN;
      RUN:     if (accept && (grp_nxt == num_q)) state_nxt = FLUSH;
      FLUSH:   if ((fill_p0 == 4'd0) && out_free) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pk_buf_p0 <= '0;
      fill_p0   <= '0;
      grp_cnt   <= '0;
      num_q     <= '0;
      word_idx  <= '0;
      base_q    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        base_q   <= base_addr;
        num_q    <= num_groups;
        grp_cnt  <= '0;
        word_idx <= '0;
      end
      if (accept) grp_cnt <= grp_nxt;

      // --- stage p0: packing buffer ---
      if (flush_part) begin
        pk_buf_p0 <= '0;
        fill_p0   <= '0;
      end else begin
        pk_buf_p0 <= buf_nxt;
        fill_p0   <= fill_nxt;
      end

      // --- stage p1: registered DRAM request ---
      if (drain || flush_part) begin
        wr_valid <= 1'b1;
        wr_addr  <= base_q + word_idx;
        wr_data  <= pk_buf_p0[63:0];
        word_idx <= word_idx + ADDR_W'(1);
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_wb_sched.sv
module tb_maxpool_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [11:0] num_groups;
  logic        in_valid;
  logic        in_len48;
  logic [63:0] in_data;
  logic        in_ready;
  logic        wr_valid;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;

  maxpool_wb_sched #(.ADDR_W(10), .CNT_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_groups (num_groups),
    .in_valid   (in_valid),
    .in_len48   (in_len48),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0]  exp_addr_q[$];
  logic [63:0] exp_data_q[$];

  int          cyc = 0;
  int          last_hs_cyc = -1;
  int          done_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_addr;
  logic [63:0] prev_data;
  logic [9:0]  ea;
  logic [63:0] ed;

  // Monitor: samples 2 time units after each falling edge, i.e. with the
  // values that the next rising edge will see.
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      if (prev_stall) begin
        checks++;
        if (!wr_valid || wr_addr != prev_addr || wr_data != prev_data) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                   wr_valid, wr_addr, wr_data, prev_addr, prev_data);
        end
      end
      if (wr_valid && wr_ready) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got a=%h d=%h want no write", wr_addr, wr_data);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          if (wr_addr != ea || wr_data != ed) begin
            errors++;
            $display("FAIL write: got a=%h d=%h want a=%h d=%h", wr_addr, wr_data, ea, ed);
          end
        end
        last_hs_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      if (dut.fill_p0 > 4'd8) begin
        errors++;
        $display("FAIL fill_overflow: got %0d want <=8", dut.fill_p0);
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] a, input logic [63:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // All driving tasks start and end aligned to a falling edge.
  task automatic do_start(input logic [9:0] b, input logic [11:0] n);
    start = 1'b1; base_addr = b; num_groups = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic l48, input logic [63:0] d);
    int n;
    in_valid = 1'b1; in_len48 = l48; in_data = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_gap);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got done=0 want 1", name);
    end else begin
      #3;
      if (chk_gap) chk({name, "_done_gap"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, {63'b0, done}, 64'd0);
    chk({name, "_idle"}, {63'b0, busy}, 64'd0);
    chk({name, "_queue_empty"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  logic [63:0] g4[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; num_groups = '0;
    in_valid = 1'b0; in_len48 = 1'b0; in_data = '0; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_wr_valid", {63'b0, wr_valid}, 64'd0);
    chk("rst_wr_addr", {54'b0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Four full 64-bit groups
    push_exp(10'h010, 64'h0123_4567_89AB_CDEF);
    push_exp(10'h011, 64'hFEDC_BA98_7654_3210);
    push_exp(10'h012, 64'h1111_2222_3333_4444);
    push_exp(10'h013, 64'h8000_0000_0000_0001);
    do_start(10'h010, 12'd4);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    send(1'b0, 64'h0123_4567_89AB_CDEF);
    send(1'b0, 64'hFEDC_BA98_7654_3210);
    send(1'b0, 64'h1111_2222_3333_4444);
    send(1'b0, 64'h8000_0000_0000_0001);
    wait_done("t1", 1'b1);

    // Four 48-bit groups, junk in the unused top 16 bits
    push_exp(10'h000, 64'hB5B6_A1A2_A3A4_A5A6);
    push_exp(10'h001, 64'hC3C4_C5C6_B1B2_B3B4);
    push_exp(10'h002, 64'hD1D2_D3D4_D5D6_C1C2);
    do_start(10'h000, 12'd4);
    send(1'b1, 64'hFFFF_A1A2_A3A4_A5A6);
    send(1'b1, 64'hFFFF_B1B2_B3B4_B5B6);
    send(1'b1, 64'hFFFF_C1C2_C3C4_C5C6);
    send(1'b1, 64'hFFFF_D1D2_D3D4_D5D6);
    wait_done("t2", 1'b0);

    // Single 48-bit group -> zero-padded flush word
    push_exp(10'h155, 64'h0000_AAAA_BBBB_CCCC);
    do_start(10'h155, 12'd1);
    send(1'b1, 64'hDEAD_AAAA_BBBB_CCCC);
    wait_done("t3", 1'b0);

    // Back-pressure with continuous 64-bit input, addresses wrapping
    g4[0] = 64'h1000_0000_0000_0001; g4[1] = 64'h2000_0000_0000_0002;
    g4[2] = 64'h3000_0000_0000_0003; g4[3] = 64'h4000_0000_0000_0004;
    g4[4] = 64'h5000_0000_0000_0005; g4[5] = 64'h6000_0000_0000_0006;
    push_exp(10'h3FE, g4[0]); push_exp(10'h3FF, g4[1]); push_exp(10'h000, g4[2]);
    push_exp(10'h001, g4[3]); push_exp(10'h002, g4[4]); push_exp(10'h003, g4[5]);
    wr_ready = 1'b0;
    do_start(10'h3FE, 12'd6);
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, g4[i]);
      end
      begin
        repeat (5) @(negedge clk);
        chk("t4_in_ready_full", {63'b0, in_ready}, 64'd0);
        chk("t4_wr_valid_held", {63'b0, wr_valid}, 64'd1);
        chk("t4_wr_addr_held", {54'b0, wr_addr}, 64'h3FE);
        wr_ready = 1'b1;
      end
    join
    wait_done("t4", 1'b0);

    // Zero groups: no writes, done two cycles after start
    start = 1'b1; base_addr = 10'h0AA; num_groups = 12'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done_early", {63'b0, done}, 64'd0);
    chk("t5_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("t5_done", {63'b0, done}, 64'd1);
    @(negedge clk);
    chk("t5_done_pulse", {63'b0, done}, 64'd0);
    chk("t5_idle", {63'b0, busy}, 64'd0);
    chk("t5_no_writes", 64'(exp_addr_q.size()), 64'd0);

    // Reset mid-RUN with fill=3 and a write pending
    wr_ready = 1'b0;
    do_start(10'h100, 12'd5);
    send(1'b0, 64'h7777_7777_7777_7777);
    send(1'b1, 64'h0000_5555_5555_5555);
    chk("t6_pre_wr_valid", {63'b0, wr_valid}, 64'd1);
    chk("t6_pre_in_ready", {63'b0, in_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("t6_rst_wr_valid", {63'b0, wr_valid}, 64'd0);
    chk("t6_rst_wr_addr", {54'b0, wr_addr}, 64'd0);
    chk("t6_rst_wr_data", wr_data, 64'd0);
    chk("t6_rst_busy", {63'b0, busy}, 64'd0);
    chk("t6_rst_done", {63'b0, done}, 64'd0);
    rst = 1'b1; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_stray_write", {63'b0, wr_valid}, 64'd0);
    push_exp(10'h020, 64'h9999_8888_7777_6666);
    do_start(10'h020, 12'd1);
    send(1'b0, 64'h9999_8888_7777_6666);
    wait_done("t6", 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
